// File: rtl/reorder_buffer.sv
// In-order retirement buffer: dispatch allocates at the tail, the CDB completes entries by tag,
// and the ready head retires through the register-file write port in the same cycle.
module reorder_buffer #(
    parameter int WIDTH   = 31,
    parameter int A_WIDTH = 4,
    parameter int DEPTH   = 8,
    parameter int T_WIDTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               alloc_valid,
    input  logic [A_WIDTH:0]   alloc_rd,
    input  logic               alloc_wen,
    output logic               alloc_ready,
    output logic [T_WIDTH:0]   alloc_tag,
    input  logic               cdb_valid,
    input  logic [T_WIDTH:0]   cdb_tag,
    input  logic [WIDTH:0]     cdb_data,
    input  logic               flush,
    output logic               regWrite,
    output logic [A_WIDTH:0]   wraddress,
    output logic [WIDTH:0]     wdata,
    output logic               commit_valid,
    output logic [T_WIDTH+1:0] count
);

    localparam logic [T_WIDTH+1:0] FULL    = (T_WIDTH+2)'(DEPTH);
    localparam logic [T_WIDTH+1:0] CNT_ONE = (T_WIDTH+2)'(1);
    localparam logic [T_WIDTH:0]   TAG_ONE = (T_WIDTH+1)'(1);

    logic [DEPTH-1:0]   busy_q, busy_d;
    logic [DEPTH-1:0]   ready_q, ready_d;
    logic [DEPTH-1:0]   wen_q;
    logic [A_WIDTH:0]   rd_q   [DEPTH];
    logic [WIDTH:0]     data_q [DEPTH];
    logic [T_WIDTH:0]   head_q, head_d;
    logic [T_WIDTH:0]   tail_q, tail_d;
    logic [T_WIDTH+1:0] count_q, count_d;

    logic do_alloc;
    logic do_cdb;

    always_comb begin
        alloc_ready  = (count_q != FULL);
        alloc_tag    = tail_q;
        do_alloc     = alloc_valid & alloc_ready & ~flush;
        // A completion aimed at the slot being allocated this cycle belongs to a dead instruction.
        do_cdb       = cdb_valid & ~flush & busy_q[cdb_tag] & ~(do_alloc & (cdb_tag == tail_q));
        commit_valid = busy_q[head_q] & ready_q[head_q] & ~flush;
        regWrite     = commit_valid & wen_q[head_q] & (rd_q[head_q] != '0);
        wraddress    = rd_q[head_q];
        wdata        = data_q[head_q];
        count        = count_q;
    end

    always_comb begin
        busy_d  = busy_q;
        ready_d = ready_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            busy_d  = '0;
            ready_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_cdb) begin
                ready_d[cdb_tag] = 1'b1;
            end
            if (commit_valid) begin
                busy_d[head_q] = 1'b0;
                head_d         = head_q + TAG_ONE;
            end
            if (do_alloc) begin
                busy_d[tail_q]  = 1'b1;
                ready_d[tail_q] = 1'b0;
                tail_d          = tail_q + TAG_ONE;
            end
            case ({do_alloc, commit_valid})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q  <= '0;
            ready_q <= '0;
            wen_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            busy_q  <= busy_d;
            ready_q <= ready_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (do_alloc) begin
                rd_q[tail_q]  <= alloc_rd;
                wen_q[tail_q] <= alloc_wen;
            end
            if (do_cdb) begin
                data_q[cdb_tag] <= cdb_data;
            end
        end
    end

endmodule
